// File: rtl/serial_rx.sv
// 8N1 serial receiver with mid-bit sampling, glitch-rejecting start detection
// and a single-entry valid/ready output holding register.
module serial_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       ready,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          rx_meta, rxs, rxs_d;
    logic          byte_done, stop_bad;

    // Synchronizer and edge history reset to the idle-high line level, so that
    // reset itself never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge
            // value of its neighbour; blocking here would collapse the chain.
            rx_meta <= rx_in;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_n   = state;
        cnt_n     = cnt + CW'(1);
        bit_idx_n = bit_idx;
        shift_n   = shift;
        byte_done = 1'b0;
        stop_bad  = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                // Requiring rxs_d=1 means a line stuck low cannot re-trigger.
                if (!rxs && rxs_d) state_n = START;
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n            = '0;
                    shift_n[bit_idx] = rxs;
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_idx_n = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n     = '0;
                    state_n   = IDLE;
                    byte_done = rxs;
                    stop_bad  = !rxs;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output holding register: a completed byte is kept only if the slot is
    // free or being emptied on this same edge; otherwise it is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= 1'b0;
            if (byte_done) begin
                if (!valid || ready) begin
                    data_out <= shift;
                    valid    <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
